// File: rtl/phy_lanes_pkg.sv
// Shared definitions for the multi-lane serial PHY: RX state encoding,
// default alignment symbol and the lane slice helper.
package phy_lanes_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

    // Low bit index of a lane's word inside a packed multi-lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/phy_lane_rx.sv
// One RX lane: input flop, deserialiser, word-phase counter, alignment FSM
// and the registered word/valid outputs.
module phy_lane_rx
    import phy_lanes_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(IDLE_SYM_DEFAULT),
    parameter int                SYNC_COUNT = 4
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              serial_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    localparam int              CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]   PHASE_MAX = CW'(DATA_W - 1);
    localparam logic [3:0]      SYNC_TGT = 4'(SYNC_COUNT);

    logic              in_bit;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word;
    logic [CW-1:0]     phase;
    logic [3:0]        match_cnt;
    logic [3:0]        match_next;
    rx_state_t         state;
    rx_state_t         state_next;
    logic              boundary;
    logic              phase_clr;
    logic              deliver;
    logic              is_idle;

    // The serial input is registered once, which sets the one extra cycle of
    // loopback latency beyond the TX output register.
    assign word     = {shreg[DATA_W-2:0], in_bit};
    assign is_idle  = (word == IDLE_SYM);
    assign boundary = (phase == PHASE_MAX);
    assign active   = (state == LOCKED);

    always_comb begin
        state_next = state;
        match_next = match_cnt;
        phase_clr  = 1'b0;
        deliver    = 1'b0;
        case (state)
            SEARCH: begin
                if (is_idle) begin
                    phase_clr  = 1'b1;
                    match_next = 4'd1;
                    state_next = (SYNC_TGT == 4'd1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_idle) begin
                        match_next = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == SYNC_TGT) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        match_next = 4'd0;
                        state_next = SEARCH;
                    end
                end
            end
            LOCKED: begin
                deliver = boundary && !is_idle;
            end
            default: begin
                state_next = SEARCH;
                match_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            in_bit    <= 1'b0;
            shreg     <= '0;
            phase     <= '0;
            match_cnt <= 4'd0;
            state     <= SEARCH;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            in_bit    <= serial_bit;
            shreg     <= word;
            state     <= state_next;
            match_cnt <= match_next;
            valid_out <= deliver;
            if (deliver) begin
                data_out <= word;
            end
            // Restarting the phase on a SEARCH hit puts the next boundary
            // exactly one word after the matched IDLE.
            if (phase_clr || boundary) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_lanes_sync.sv
// N-lane serial PHY on one bit clock: shared-timing MSB-first TX serialisers
// with IDLE fill, per-lane RX alignment, and selectable loopback.
module phy_lanes_sync
    import phy_lanes_pkg::*;
#(
    parameter int                N_LANES    = 2,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(IDLE_SYM_DEFAULT),
    parameter int                SYNC_COUNT = 4
) (
    input  logic                      clk_8f,
    input  logic                      reset,
    input  logic                      loopback,
    input  logic [N_LANES*DATA_W-1:0] data_in,
    input  logic [N_LANES-1:0]        valid_in,
    output logic                      tx_ready,
    output logic [N_LANES-1:0]        serial_out,
    input  logic [N_LANES-1:0]        serial_in,
    output logic [N_LANES*DATA_W-1:0] data_out,
    output logic [N_LANES-1:0]        valid_out,
    output logic [N_LANES-1:0]        active
);

    localparam int            CW       = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    logic [CW-1:0] tx_cnt;

    assign tx_ready = (tx_cnt == CNT_LAST);

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
        end else if (tx_ready) begin
            tx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [DATA_W-1:0] tx_load;
        logic [DATA_W-1:0] tx_shreg;
        logic              tx_bit;
        logic              rx_bit;

        assign tx_load = valid_in[i] ? data_in[lane_lo(i, DATA_W) +: DATA_W] : IDLE_SYM;

        // On load the MSB goes straight to the output flop so it leads the
        // word in the very next cycle; the rest drains one bit per cycle.
        always_ff @(posedge clk_8f or negedge reset) begin
            if (!reset) begin
                tx_shreg <= IDLE_SYM;
                tx_bit   <= 1'b0;
            end else if (tx_ready) begin
                tx_bit   <= tx_load[DATA_W-1];
                tx_shreg <= {tx_load[DATA_W-2:0], 1'b0};
            end else begin
                tx_bit   <= tx_shreg[DATA_W-1];
                tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
            end
        end

        assign serial_out[i] = tx_bit;
        assign rx_bit        = loopback ? tx_bit : serial_in[i];

        phy_lane_rx #(
            .DATA_W     (DATA_W),
            .IDLE_SYM   (IDLE_SYM),
            .SYNC_COUNT (SYNC_COUNT)
        ) u_rx (
            .clk_8f     (clk_8f),
            .reset      (reset),
            .serial_bit (rx_bit),
            .data_out   (data_out[lane_lo(i, DATA_W) +: DATA_W]),
            .valid_out  (valid_out[i]),
            .active     (active[i])
        );
    end

endmodule

// File: tb/tb_phy_lanes_sync.sv
// Scoreboard bench for phy_lanes_sync with 2 lanes of 8 bits, IDLE 8'hBC,
// four-IDLE lock: loopback traffic, reset behaviour and external alignment.
module tb_phy_lanes_sync;

    localparam int         N_LANES    = 2;
    localparam int         DATA_W     = 8;
    localparam int         SYNC_COUNT = 4;
    localparam logic [7:0] IDLE       = 8'hBC;

    logic        clk_8f = 1'b0;
    logic        reset = 1'b0;
    logic        loopback = 1'b1;
    logic [15:0] data_in = '0;
    logic [1:0]  valid_in = '0;
    logic [1:0]  serial_in = '0;
    logic        tx_ready;
    logic [1:0]  serial_out;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [1:0]  active;

    phy_lanes_sync #(
        .N_LANES    (N_LANES),
        .DATA_W     (DATA_W),
        .IDLE_SYM   (IDLE),
        .SYNC_COUNT (SYNC_COUNT)
    ) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .loopback   (loopback),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active     (active)
    );

    always #5 clk_8f = ~clk_8f;

    int cyc = 0;
    always @(posedge clk_8f) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every valid_out pulse must match the oldest expected
    // word for that lane, both in data and in arrival cycle.
    always @(negedge clk_8f) begin : mon
        exp_t e;
        if (valid_out[0] === 1'b1) begin
            if (sb0.size() == 0) begin
                check_val("lane0 unexpected valid", 32'd1, 32'd0);
            end else begin
                e = sb0.pop_front();
                check_val("lane0 data", 32'(data_out[7:0]), 32'(e.data));
                check_val("lane0 cycle", 32'(cyc), 32'(e.at));
            end
        end
        if (valid_out[1] === 1'b1) begin
            if (sb1.size() == 0) begin
                check_val("lane1 unexpected valid", 32'd1, 32'd0);
            end else begin
                e = sb1.pop_front();
                check_val("lane1 data", 32'(data_out[15:8]), 32'(e.data));
                check_val("lane1 cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk_8f);
            n++;
        end while (tx_ready !== 1'b1 && n < 20);
        if (tx_ready !== 1'b1) check_val("tx_ready timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_word(input logic [15:0] d, input logic [1:0] v);
        wait_ready();
        data_in  = d;
        valid_in = v;
        if (v[0] && d[7:0] != IDLE)  sb0.push_back('{d[7:0], cyc + 10});
        if (v[1] && d[15:8] != IDLE) sb1.push_back('{d[15:8], cyc + 10});
        @(negedge clk_8f);
        valid_in = 2'b00;
    endtask

    task automatic release_and_lock(input string tag);
        logic [7:0] idle_v;
        idle_v = IDLE;
        @(negedge clk_8f);
        reset = 1'b1;
        #1;
        check_val({tag, " tx_ready first cycle"}, 32'(tx_ready), 32'd0);
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk_8f);
            if (j == 7) check_val({tag, " tx_ready strobe"}, 32'(tx_ready), 32'd1);
            if (j >= 8 && j <= 15)
                check_val({tag, " serial_out idle"}, 32'(serial_out), 32'({2{idle_v[15-j]}}));
            if (j == 40) check_val({tag, " active before lock"}, 32'(active), 32'd0);
            if (j == 41) check_val({tag, " active after lock"}, 32'(active), 32'd3);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " tx_ready"},   32'(tx_ready),   32'd0);
        check_val({tag, " serial_out"}, 32'(serial_out), 32'd0);
        check_val({tag, " data_out"},   32'(data_out),   32'd0);
        check_val({tag, " valid_out"},  32'(valid_out),  32'd0);
        check_val({tag, " active"},     32'(active),     32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] words [10];
        logic [7:0] w;
        logic       b;
        int         s;

        // Reset state, then IDLE-only lock.
        repeat (3) @(negedge clk_8f);
        #1;
        check_reset_outputs("reset");
        release_and_lock("lock");

        // Single word on both lanes.
        drive_word({8'h3C, 8'hA5}, 2'b11);
        repeat (24) @(negedge clk_8f);
        check_val("hold after A5/3C", 32'(data_out), 32'h3CA5);
        check_val("valid low after A5/3C", 32'(valid_out), 32'd0);

        // Back-to-back burst on lane 0 only.
        drive_word({8'h00, 8'h01}, 2'b01);
        drive_word({8'h00, 8'h02}, 2'b01);
        drive_word({8'h00, 8'h03}, 2'b01);
        repeat (24) @(negedge clk_8f);
        check_val("hold after burst", 32'(data_out), 32'h3C03);

        // IDLE sent as valid data is dropped by RX.
        drive_word({8'h00, IDLE}, 2'b01);
        repeat (24) @(negedge clk_8f);
        check_val("hold after valid idle", 32'(data_out), 32'h3C03);

        // Reset in the middle of a word in flight.
        drive_word({8'h77, 8'h66}, 2'b11);
        repeat (3) @(negedge clk_8f);
        #2;
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        #1;
        check_reset_outputs("mid-word reset");
        repeat (2) @(negedge clk_8f);
        release_and_lock("relock");

        // External input, 3-bit offset, third IDLE corrupted.
        @(negedge clk_8f);
        #2;
        reset     = 1'b0;
        loopback  = 1'b0;
        serial_in = 2'b00;
        repeat (2) @(negedge clk_8f);
        reset = 1'b1;
        words = '{IDLE, IDLE, 8'h00, IDLE, IDLE, IDLE, IDLE, 8'h5A, IDLE, IDLE};
        s = 0;
        for (int j = 0; j < 83; j++) begin
            @(negedge clk_8f);
            if (j == 0) begin
                s = cyc;
                sb0.push_back('{8'h5A, s + 68});
                sb1.push_back('{8'h5A, s + 68});
            end
            if (j == 59) check_val("ext active before relock", 32'(active), 32'd0);
            if (j == 60) check_val("ext active after relock", 32'(active), 32'd3);
            if (j < 3) begin
                b = 1'b0;
            end else begin
                w = words[(j - 3) / 8];
                b = w[7 - ((j - 3) % 8)];
            end
            serial_in = {b, b};
        end
        @(negedge clk_8f);
        #2;
        reset = 1'b0;
        repeat (2) @(negedge clk_8f);

        check_val("lane0 scoreboard drained", 32'(sb0.size()), 32'd0);
        check_val("lane1 scoreboard drained", 32'(sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_lanes_sync.md
Name: phy_lanes_sync

Overview:
- Parametrised N-lane, W-bit serial PHY on a single bit clock.
- Per lane, the TX side serialises parallel words MSB first and inserts an IDLE symbol whenever no valid data is offered.
- The RX side deserialises, finds word alignment by searching for IDLE, locks after SYNC_COUNT aligned IDLE words, then delivers non-IDLE words with a valid pulse.
- Internal or external loopback is selectable per instance; it is the next generation of the fixed 2-lane, 8-bit, multi-clock PHY pair.

Parameters:
- N_LANES, 2, number of independent lanes.
- DATA_W, 8, word width in bits; must be at least 4.
- IDLE_SYM, 8'hBC (DATA_W bits), symbol sent when the lane is not valid; also the RX alignment pattern.
- SYNC_COUNT, 4, consecutive aligned IDLE words required to lock; range 1..15.

Ports:
- clk_8f  in  1  bit clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- loopback  in  1  1: RX lane i takes serial_out[i]; 0: RX lane i takes serial_in[i].
- data_in  in  N_LANES*DATA_W  TX words; lane i occupies bits [i*DATA_W +: DATA_W].
- valid_in  in  N_LANES  TX word valid per lane.
- tx_ready  out  1  word-boundary strobe; data_in/valid_in are sampled only when it is 1.
- serial_out  out  N_LANES  registered TX serial bit per lane.
- serial_in  in  N_LANES  external RX serial bit per lane.
- data_out  out  N_LANES*DATA_W  RX words, same lane packing as data_in.
- valid_out  out  N_LANES  one-cycle pulse per delivered word.
- active  out  N_LANES  lane is in LOCKED.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - tx word counter = 0, tx_ready = 0, serial_out = 0;
  - all TX shift registers = IDLE_SYM;
  - RX shift registers = 0, data_out = 0, valid_out = 0, active = 0;
  - RX FSM = SEARCH, match count = 0, rx phase = 0.
  - Reset mid-word abandons the word with no partial output.
- TX timing:
  - A free-running counter counts 0..DATA_W-1. tx_ready = 1 when the counter equals DATA_W-1, so it is high 1 cycle in every DATA_W, and is 0 in the first cycle after reset release.
  - In a tx_ready cycle T, each lane loads data_in (valid_in=1) or IDLE_SYM (valid_in=0) into its TX shift register.
  - Word bit DATA_W-1-k appears on serial_out in cycle T+1+k, MSB first.
  - All lanes share word timing.
- Sending IDLE_SYM as valid data is legal on TX. RX treats that word as idle and drops it; this is documented behaviour, not an error.
- RX, per lane, is independent:
  - The shift register shifts in the selected serial bit every cycle.
  - `word` is the next-state shift value.
  - The RX phase counter wraps at DATA_W-1; a boundary is the cycle in which it wraps.
- RX FSM:
  - SEARCH: compares every cycle. If word == IDLE_SYM, go to ALIGN with match count = 1 and phase reset so the next boundary is DATA_W cycles later.
  - ALIGN: at each boundary:
    - word == IDLE_SYM: increment the count; on reaching SYNC_COUNT go to LOCKED and set active=1.
    - otherwise: go to SEARCH and clear the count.
  - With SYNC_COUNT = 1, SEARCH goes directly to LOCKED.
  - LOCKED: at each boundary:
    - word != IDLE_SYM: data_out lane = word, valid_out = 1 for one cycle.
    - otherwise: valid_out = 0 and data_out holds.
  - LOCKED persists until reset; there is no lock-loss detection in this generation.
- Latency (loopback=1, after lock): a word sampled in tx_ready cycle T appears on data_out with valid_out=1 in cycle T+DATA_W+2.
- Switching loopback mid-stream is allowed. Lock state is not cleared; the user resets to re-acquire.
- Widths: counters are ceil(log2(DATA_W)) bits; the match count is 4 bits with no overflow (saturating is irrelevant because SYNC_COUNT ≤ 15).

Decomposition:
- Package phy_lanes_pkg:
  - RX state encoding: SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2;
  - default IDLE_SYM constant;
  - lane slice helper.
- Sub-module phy_lane_rx: one lane's RX shift register, phase counter, FSM and output registers. It is instantiated N_LANES times in a generate loop.
- TX stays in the top level because the word counter is shared.

Test Plan (N_LANES=2, DATA_W=8, IDLE_SYM=8'hBC, SYNC_COUNT=4, loopback=1):
1. Release reset with valid_in=0 for 6 words -> both lanes' active rises during the 5th word after the first full IDLE shifts in; valid_out stays 0; serial_out shows 10111100 repeatedly.
2. After lock, drive lane0 8'hA5, lane1 8'h3C valid for one tx_ready cycle T -> in cycle T+10, data_out = {8'h3C, 8'hA5} and valid_out = 2'b11 for exactly one cycle; both lanes then hold while IDLE follows.
3. After lock, drive a back-to-back burst lane0 = 8'h01, 8'h02, 8'h03 -> three valid_out[0] pulses spaced 8 cycles apart with data 01, 02, 03; lane1 valid_out stays 0.
4. loopback=0 with serial_in = IDLE stream shifted by 3 bits, corrupting the 3rd IDLE -> FSM returns to SEARCH and re-locks only after 4 further clean IDLEs; the first post-lock word is aligned correctly.
5. Assert reset mid-word during traffic -> all outputs take their reset values immediately (asynchronous); no valid_out pulse for the interrupted word; re-lock follows as in scenario 1.
6. Send valid data 8'hBC on lane0 after lock -> no valid_out pulse and data_out unchanged.
